// File: rtl/load_buffer_pkg.sv
// Shared load-queue constants, state encoding, entry payload and mem-length helper.
package load_buffer_pkg;

    localparam int unsigned LB_DEPTH   = 8;
    localparam int unsigned LB_WIDTH   = 3;
    localparam int unsigned ROB_WIDTH  = 4;
    localparam int unsigned ID_WIDTH   = 32;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = LB_WIDTH + 1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] LEN_BYTE  = 2'd0;
    localparam logic [1:0] LEN_HALF  = 2'd1;
    localparam logic [1:0] LEN_WORD  = 2'd2;
    localparam logic [1:0] IO_PREFIX = 2'b11;

    localparam logic [ROB_WIDTH-1:0] NO_TAG = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_MEM,
        ST_BROADCAST,
        ST_DRAIN
    } lb_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [ROB_WIDTH-1:0]  dest;
        logic [2:0]            funct3;
    } lb_entry_t;

    function automatic logic [1:0] mem_len(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: mem_len = LEN_BYTE;
            F3_LH, F3_LHU: mem_len = LEN_HALF;
            default:       mem_len = LEN_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_buffer_extend.sv
// Combinational sign/zero extension of right-aligned load data by funct3.
module lb_load_extend
    import load_buffer_pkg::*;
(
    input  logic [2:0]          funct3_in,
    input  logic [ID_WIDTH-1:0] data_in,
    output logic [ID_WIDTH-1:0] result_c
);

    always_comb begin
        case (funct3_in)
            F3_LB:   result_c = {{(ID_WIDTH-8){data_in[7]}}, data_in[7:0]};
            F3_LH:   result_c = {{(ID_WIDTH-16){data_in[15]}}, data_in[15:0]};
            F3_LBU:  result_c = {{(ID_WIDTH-8){1'b0}}, data_in[7:0]};
            F3_LHU:  result_c = {{(ID_WIDTH-16){1'b0}}, data_in[15:0]};
            default: result_c = data_in;
        endcase
    end

endmodule

// File: rtl/load_buffer.sv
// In-order load queue: issues loads to memory one at a time and broadcasts results on the CDB.
module load_buffer
    import load_buffer_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rs_lbuffer_en_in,
    input  logic [ADDR_WIDTH-1:0] rs_lbuffer_a_in,
    input  logic [ROB_WIDTH-1:0]  rs_lbuffer_dest_in,
    input  logic [2:0]            rs_lbuffer_funct3_in,
    output logic                  lbuffer_rs_rdy_out,
    input  logic                  rob_lbuffer_rst_in,
    input  logic [ROB_WIDTH-1:0]  rob_lbuffer_head_in,
    output logic                  lbuffer_mem_req_out,
    output logic [ADDR_WIDTH-1:0] lbuffer_mem_addr_out,
    output logic [1:0]            lbuffer_mem_len_out,
    input  logic                  mem_lbuffer_done_in,
    input  logic [ID_WIDTH-1:0]   mem_lbuffer_data_in,
    output logic                  lbuffer_cdb_en_out,
    output logic [ROB_WIDTH-1:0]  lbuffer_cdb_b_out,
    output logic [ID_WIDTH-1:0]   lbuffer_cdb_result_out,
    input  logic                  cdb_lbuffer_grant_in
);

    lb_state_e             state_q, state_d;
    lb_entry_t             entry_q [LB_DEPTH];
    lb_entry_t             entry_d [LB_DEPTH];
    logic [LB_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  rs_rdy_q, rs_rdy_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            len_q, len_d;
    logic                  cdb_en_q, cdb_en_d;
    logic [ROB_WIDTH-1:0]  cdb_b_q, cdb_b_d;
    logic [ID_WIDTH-1:0]   result_q, result_d;

    lb_entry_t             head_e;
    logic                  issuable;
    logic                  push, pop;
    logic [ID_WIDTH-1:0]   ext_result_c;

    assign head_e = entry_q[head_q];

    // IO loads must wait until they are the oldest uncommitted instruction.
    assign issuable = (head_e.addr[17:16] != IO_PREFIX) || (rob_lbuffer_head_in == head_e.dest);

    lb_load_extend u_extend (
        .funct3_in (head_e.funct3),
        .data_in   (mem_lbuffer_data_in),
        .result_c  (ext_result_c)
    );

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rs_rdy_d = rs_rdy_q;
        req_d    = req_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cdb_en_d = cdb_en_q;
        cdb_b_d  = cdb_b_q;
        result_d = result_q;
        push     = 1'b0;
        pop      = 1'b0;

        if (rdy_in) begin
            push = rs_lbuffer_en_in && (count_q != CNT_WIDTH'(LB_DEPTH)) && !rob_lbuffer_rst_in;

            case (state_q)
                ST_IDLE: begin
                    if ((count_q != '0) && issuable) begin
                        state_d = ST_WAIT_MEM;
                        req_d   = 1'b1;
                        addr_d  = head_e.addr;
                        len_d   = mem_len(head_e.funct3);
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_lbuffer_done_in) begin
                        state_d  = ST_BROADCAST;
                        req_d    = 1'b0;
                        cdb_en_d = 1'b1;
                        cdb_b_d  = head_e.dest;
                        result_d = ext_result_c;
                    end
                end
                ST_BROADCAST: begin
                    if (cdb_lbuffer_grant_in) begin
                        pop      = 1'b1;
                        cdb_en_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mem_lbuffer_done_in) begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (push) begin
                entry_d[tail_q] = '{addr: rs_lbuffer_a_in, dest: rs_lbuffer_dest_in,
                                    funct3: rs_lbuffer_funct3_in};
                tail_d = tail_q + LB_WIDTH'(1);
            end
            head_d  = head_q + LB_WIDTH'(pop);
            count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

            // An outstanding memory read must still be absorbed after a flush.
            if (rob_lbuffer_rst_in) begin
                head_d   = '0;
                tail_d   = '0;
                count_d  = '0;
                cdb_en_d = 1'b0;
                if ((state_q == ST_WAIT_MEM || state_q == ST_DRAIN) && !mem_lbuffer_done_in) begin
                    state_d = ST_DRAIN;
                    req_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end

            rs_rdy_d = (count_d != CNT_WIDTH'(LB_DEPTH));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            for (int i = 0; i < LB_DEPTH; i++) entry_q[i] <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rs_rdy_q <= 1'b1;
            req_q    <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cdb_en_q <= 1'b0;
            cdb_b_q  <= NO_TAG;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rs_rdy_q <= rs_rdy_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cdb_en_q <= cdb_en_d;
            cdb_b_q  <= cdb_b_d;
            result_q <= result_d;
        end
    end

    assign lbuffer_rs_rdy_out     = rs_rdy_q;
    assign lbuffer_mem_req_out    = req_q;
    assign lbuffer_mem_addr_out   = addr_q;
    assign lbuffer_mem_len_out    = len_q;
    assign lbuffer_cdb_en_out     = cdb_en_q;
    assign lbuffer_cdb_b_out      = cdb_b_q;
    assign lbuffer_cdb_result_out = result_q;

endmodule
